// File: rtl/rename_nwide.sv
// N-wide rename stage: intra-group RAW/WAW resolution, free-list allocation, all-or-nothing dispatch.
// Optional RENAME_PARTIAL_DISPATCH_EN accepts the longest prefix that fits all budgets.
module rename_nwide #(
  parameter int WIDTH        = 2,
  parameter int NUM_ARCH     = 32,
  parameter int LOG_ARCH     = 5,
  parameter int NUM_PHYS     = 64,
  parameter int LOG_PHYS     = 6,
  parameter int CW           = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         Flush_IN,
  input  logic [WIDTH-1:0]             Instr_valid_IN,
  input  logic [WIDTH*LOG_ARCH-1:0]    Ra_IN,
  input  logic [WIDTH*LOG_ARCH-1:0]    Rb_IN,
  input  logic [WIDTH*LOG_ARCH-1:0]    Rd_IN,
  input  logic [WIDTH-1:0]             RegWrite_IN,
  input  logic [WIDTH-1:0]             MemRead_IN,
  input  logic [WIDTH-1:0]             MemWrite_IN,
  input  logic [NUM_ARCH*LOG_PHYS-1:0] Frat_map_IN,
  input  logic [NUM_PHYS-1:0]          Busy_IN,
  input  logic [WIDTH*LOG_PHYS-1:0]    Free_regs_IN,
  input  logic [CW-1:0]                Free_count_IN,
  input  logic [CW-1:0]                Rob_free_IN,
  input  logic [CW-1:0]                Iq_free_IN,
  input  logic [CW-1:0]                Lsq_free_IN,
  output logic [CW-1:0]                Pop_count,
  output logic [CW-1:0]                Grabbed_regs,
  output logic [WIDTH-1:0]             Out_valid,
  output logic [WIDTH*LOG_PHYS-1:0]    Out_src_a,
  output logic [WIDTH*LOG_PHYS-1:0]    Out_src_b,
  output logic [WIDTH-1:0]             Out_rdy_a,
  output logic [WIDTH-1:0]             Out_rdy_b,
  output logic [WIDTH*LOG_PHYS-1:0]    Out_dest,
  output logic [WIDTH*LOG_PHYS-1:0]    Out_old_dest,
  output logic [WIDTH-1:0]             Out_has_dest,
  output logic [WIDTH-1:0]             Out_lsq,
  output logic [WIDTH-1:0]             Frat_we,
  output logic [WIDTH*LOG_ARCH-1:0]    Frat_arch,
  output logic [WIDTH*LOG_PHYS-1:0]    Frat_phys,
  output logic                         Blocked
);

  localparam logic STATE_RUN   = 1'b0;
  localparam logic STATE_FLUSH = 1'b1;

  logic                      state;
  logic [CW-1:0]             flush_cnt;
  logic                      prefix;
  logic [WIDTH-1:0]          slot_v, need_d, need_m, take, rdy_a, rdy_b;
  logic [WIDTH*LOG_PHYS-1:0] dest_flat, src_a, src_b, old_dest, take_p;
  logic [WIDTH*LOG_ARCH-1:0] wr_a;
  logic [CW-1:0]             n_cnt, d_cnt, m_cnt, take_n, take_d;
  logic                      hold;

  // Valid slots, per-slot needs, and in-order free-list assignment.
  always_comb begin
    prefix    = 1'b1;
    slot_v    = '0;
    need_d    = '0;
    need_m    = '0;
    dest_flat = '0;
    n_cnt     = '0;
    d_cnt     = '0;
    m_cnt     = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      prefix    = prefix & Instr_valid_IN[i];
      slot_v[i] = prefix;
      need_d[i] = prefix && RegWrite_IN[i] && (Rd_IN[i*LOG_ARCH +: LOG_ARCH] != '0);
      need_m[i] = prefix && (MemRead_IN[i] || MemWrite_IN[i]);
      if (need_d[i])
        dest_flat[i*LOG_PHYS +: LOG_PHYS] = Free_regs_IN[int'(d_cnt)*LOG_PHYS +: LOG_PHYS];
      n_cnt = n_cnt + CW'(slot_v[i]);
      d_cnt = d_cnt + CW'(need_d[i]);
      m_cnt = m_cnt + CW'(need_m[i]);
    end
  end

  // Source / old-dest lookup; later matching j overrides earlier, so the nearest writer wins.
  always_comb begin
    logic [LOG_ARCH-1:0] ra, rb, rd, rdj;
    logic [LOG_PHYS-1:0] pa, pb, dj;
    src_a    = '0;
    src_b    = '0;
    old_dest = '0;
    rdy_a    = '0;
    rdy_b    = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ra = Ra_IN[i*LOG_ARCH +: LOG_ARCH];
      rb = Rb_IN[i*LOG_ARCH +: LOG_ARCH];
      rd = Rd_IN[i*LOG_ARCH +: LOG_ARCH];
      pa = Frat_map_IN[int'(ra)*LOG_PHYS +: LOG_PHYS];
      pb = Frat_map_IN[int'(rb)*LOG_PHYS +: LOG_PHYS];
      src_a[i*LOG_PHYS +: LOG_PHYS]    = pa;
      src_b[i*LOG_PHYS +: LOG_PHYS]    = pb;
      rdy_a[i]                         = !Busy_IN[pa];
      rdy_b[i]                         = !Busy_IN[pb];
      old_dest[i*LOG_PHYS +: LOG_PHYS] = Frat_map_IN[int'(rd)*LOG_PHYS +: LOG_PHYS];
      for (int unsigned j = 0; j < i; j++) begin
        rdj = Rd_IN[j*LOG_ARCH +: LOG_ARCH];
        dj  = dest_flat[j*LOG_PHYS +: LOG_PHYS];
        if (need_d[j] && rdj == ra) begin
          src_a[i*LOG_PHYS +: LOG_PHYS] = dj;
          rdy_a[i] = 1'b0;
        end
        if (need_d[j] && rdj == rb) begin
          src_b[i*LOG_PHYS +: LOG_PHYS] = dj;
          rdy_b[i] = 1'b0;
        end
        if (need_d[j] && rdj == rd)
          old_dest[i*LOG_PHYS +: LOG_PHYS] = dj;
      end
      if (ra == '0) begin
        src_a[i*LOG_PHYS +: LOG_PHYS] = '0;
        rdy_a[i] = 1'b1;
      end
      if (rb == '0) begin
        src_b[i*LOG_PHYS +: LOG_PHYS] = '0;
        rdy_b[i] = 1'b1;
      end
      if (!need_d[i])
        old_dest[i*LOG_PHYS +: LOG_PHYS] = '0;
    end
  end

  // Dispatch budget check.
  always_comb begin
    take   = '0;
    take_n = '0;
    take_d = '0;
`ifdef RENAME_PARTIAL_DISPATCH_EN
    begin
      logic          fit;
      logic [CW-1:0] cn, cd, cm;
      fit = 1'b1;
      cn  = '0;
      cd  = '0;
      cm  = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cn = cn + CW'(slot_v[i]);
        cd = cd + CW'(need_d[i]);
        cm = cm + CW'(need_m[i]);
        if (fit && slot_v[i] && cn <= Rob_free_IN && cn <= Iq_free_IN &&
            cd <= Free_count_IN && cm <= Lsq_free_IN) begin
          take[i] = 1'b1;
          take_n  = cn;
          take_d  = cd;
        end else begin
          fit = 1'b0;
        end
      end
    end
`else
    if (n_cnt != '0 && n_cnt <= Rob_free_IN && n_cnt <= Iq_free_IN &&
        d_cnt <= Free_count_IN && m_cnt <= Lsq_free_IN) begin
      take   = slot_v;
      take_n = n_cnt;
      take_d = d_cnt;
    end
`endif
  end

  always_comb begin
    take_p = '0;
    wr_a   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      take_p[i*LOG_PHYS +: LOG_PHYS] = {LOG_PHYS{take[i]}};
      wr_a[i*LOG_ARCH +: LOG_ARCH]   = {LOG_ARCH{take[i] & need_d[i]}};
    end
  end

  assign hold      = !RESET || Flush_IN || (state == STATE_FLUSH);
  assign Pop_count = hold ? '0 : take_n;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= STATE_RUN;
      flush_cnt <= '0;
    end else if (Flush_IN) begin
      state     <= STATE_FLUSH;
      flush_cnt <= CW'(FLUSH_CYCLES);
    end else if (state == STATE_FLUSH) begin
      flush_cnt <= flush_cnt - CW'(1);
      if (flush_cnt == CW'(1))
        state <= STATE_RUN;
    end
  end

  // Reset, a flush edge and every FLUSH-state edge all present an empty, blocked stage.
  always_ff @(posedge CLK) begin
    if (hold) begin
      Grabbed_regs <= '0;
      Out_valid    <= '0;
      Out_src_a    <= '0;
      Out_src_b    <= '0;
      Out_rdy_a    <= '0;
      Out_rdy_b    <= '0;
      Out_dest     <= '0;
      Out_old_dest <= '0;
      Out_has_dest <= '0;
      Out_lsq      <= '0;
      Frat_we      <= '0;
      Frat_arch    <= '0;
      Frat_phys    <= '0;
      Blocked      <= 1'b1;
    end else begin
      Grabbed_regs <= take_d;
      Out_valid    <= take;
      Out_src_a    <= src_a & take_p;
      Out_src_b    <= src_b & take_p;
      Out_rdy_a    <= rdy_a & take;
      Out_rdy_b    <= rdy_b & take;
      Out_dest     <= dest_flat & take_p;
      Out_old_dest <= old_dest & take_p;
      Out_has_dest <= need_d & take;
      Out_lsq      <= need_m & take;
      Frat_we      <= need_d & take;
      Frat_arch    <= Rd_IN & wr_a;
      Frat_phys    <= dest_flat & take_p;
      Blocked      <= (n_cnt == '0) || (take_n < n_cnt);
    end
  end

endmodule

// File: tb/tb_rename_nwide.sv
// Directed bench for rename_nwide (WIDTH=2); expectations follow the build's dispatch mode.
module tb_rename_nwide;
  localparam int WIDTH = 2, NUM_ARCH = 32, LOG_ARCH = 5, NUM_PHYS = 64, LOG_PHYS = 6;
  localparam int CW = 3, FLUSH_CYCLES = 2;

  logic CLK, RESET, Flush_IN;
  logic [WIDTH-1:0] Instr_valid_IN, RegWrite_IN, MemRead_IN, MemWrite_IN;
  logic [WIDTH*LOG_ARCH-1:0] Ra_IN, Rb_IN, Rd_IN;
  logic [NUM_ARCH*LOG_PHYS-1:0] Frat_map_IN;
  logic [NUM_PHYS-1:0] Busy_IN;
  logic [WIDTH*LOG_PHYS-1:0] Free_regs_IN;
  logic [CW-1:0] Free_count_IN, Rob_free_IN, Iq_free_IN, Lsq_free_IN;
  logic [CW-1:0] Pop_count, Grabbed_regs;
  logic [WIDTH-1:0] Out_valid, Out_rdy_a, Out_rdy_b, Out_has_dest, Out_lsq, Frat_we;
  logic [WIDTH*LOG_PHYS-1:0] Out_src_a, Out_src_b, Out_dest, Out_old_dest, Frat_phys;
  logic [WIDTH*LOG_ARCH-1:0] Frat_arch;
  logic Blocked;

  rename_nwide #(.WIDTH(WIDTH), .NUM_ARCH(NUM_ARCH), .LOG_ARCH(LOG_ARCH), .NUM_PHYS(NUM_PHYS),
                 .LOG_PHYS(LOG_PHYS), .CW(CW), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .CLK(CLK), .RESET(RESET), .Flush_IN(Flush_IN), .Instr_valid_IN(Instr_valid_IN),
    .Ra_IN(Ra_IN), .Rb_IN(Rb_IN), .Rd_IN(Rd_IN), .RegWrite_IN(RegWrite_IN),
    .MemRead_IN(MemRead_IN), .MemWrite_IN(MemWrite_IN), .Frat_map_IN(Frat_map_IN),
    .Busy_IN(Busy_IN), .Free_regs_IN(Free_regs_IN), .Free_count_IN(Free_count_IN),
    .Rob_free_IN(Rob_free_IN), .Iq_free_IN(Iq_free_IN), .Lsq_free_IN(Lsq_free_IN),
    .Pop_count(Pop_count), .Grabbed_regs(Grabbed_regs), .Out_valid(Out_valid),
    .Out_src_a(Out_src_a), .Out_src_b(Out_src_b), .Out_rdy_a(Out_rdy_a), .Out_rdy_b(Out_rdy_b),
    .Out_dest(Out_dest), .Out_old_dest(Out_old_dest), .Out_has_dest(Out_has_dest),
    .Out_lsq(Out_lsq), .Frat_we(Frat_we), .Frat_arch(Frat_arch), .Frat_phys(Frat_phys),
    .Blocked(Blocked)
  );

  int checks = 0;
  int errors = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_slots();
    Instr_valid_IN = '0; RegWrite_IN = '0; MemRead_IN = '0; MemWrite_IN = '0;
    Ra_IN = '0; Rb_IN = '0; Rd_IN = '0;
  endtask

  task automatic slot(input int i, input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic mw);
    Instr_valid_IN[i] = 1'b1;
    Ra_IN[i*LOG_ARCH +: LOG_ARCH] = ra;
    Rb_IN[i*LOG_ARCH +: LOG_ARCH] = rb;
    Rd_IN[i*LOG_ARCH +: LOG_ARCH] = rd;
    RegWrite_IN[i] = rw;
    MemRead_IN[i]  = mr;
    MemWrite_IN[i] = mw;
  endtask

  task automatic set_free(input logic [5:0] f0, input logic [5:0] f1, input logic [2:0] cnt);
    Free_regs_IN  = {f1, f0};
    Free_count_IN = cnt;
  endtask

  // add r3<-r1,r2 ; add r4<-r3,r3 with free {40,41}
  task automatic group1();
    clear_slots();
    slot(0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    slot(1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
    set_free(6'd40, 6'd41, 3'd2);
  endtask

  initial begin
    RESET = 1'b0; Flush_IN = 1'b0; Busy_IN = '0;
    Rob_free_IN = 3'd2; Iq_free_IN = 3'd2; Lsq_free_IN = 3'd2;
    for (int r = 0; r < NUM_ARCH; r++) Frat_map_IN[r*LOG_PHYS +: LOG_PHYS] = 6'(r);
    group1();

    // reset with valid traffic present
    @(negedge CLK); #1 chk("pop_in_reset", Pop_count, 0);
    @(posedge CLK); #1;
    chk("rst_blocked", Blocked, 1);
    chk("rst_valid", Out_valid, 0);
    chk("rst_grabbed", Grabbed_regs, 0);
    chk("rst_frat_we", Frat_we, 0);

    // intra-group RAW
    @(negedge CLK); RESET = 1'b1; group1(); #1 chk("t1_pop", Pop_count, 2);
    @(posedge CLK); #1;
    chk("t1_valid", Out_valid, 2'b11);
    chk("t1_dest", Out_dest, {6'd41, 6'd40});
    chk("t1_src_a", Out_src_a, {6'd40, 6'd1});
    chk("t1_src_b", Out_src_b, {6'd40, 6'd2});
    chk("t1_rdy_a", Out_rdy_a, 2'b01);
    chk("t1_rdy_b", Out_rdy_b, 2'b01);
    chk("t1_old", Out_old_dest, {6'd4, 6'd3});
    chk("t1_arch", Frat_arch, {5'd4, 5'd3});
    chk("t1_grabbed", Grabbed_regs, 2);
    chk("t1_blocked", Blocked, 0);

    // WAW on r5, busy source, r0 source
    @(negedge CLK);
    clear_slots();
    Frat_map_IN[5*LOG_PHYS +: LOG_PHYS] = 6'd7;
    Busy_IN[1] = 1'b1;
    slot(0, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    slot(1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    set_free(6'd10, 6'd11, 3'd2);
    #1 chk("t2_pop", Pop_count, 2);
    @(posedge CLK); #1;
    chk("t2_old", Out_old_dest, {6'd10, 6'd7});
    chk("t2_we", Frat_we, 2'b11);
    chk("t2_phys", Frat_phys, {6'd11, 6'd10});
    chk("t2_src_a", Out_src_a, {6'd10, 6'd1});
    chk("t2_rdy_a", Out_rdy_a, 2'b00);
    chk("t2_src_b", Out_src_b, {6'd0, 6'd2});
    chk("t2_rdy_b", Out_rdy_b, 2'b11);

    // free list short by one
    @(negedge CLK);
    clear_slots(); Busy_IN = '0;
    slot(0, 5'd1, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0);
    slot(1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0);
    set_free(6'd20, 6'd21, 3'd1);
`ifdef RENAME_PARTIAL_DISPATCH_EN
    #1 chk("t3_pop", Pop_count, 1);
    @(posedge CLK); #1;
    chk("t3_valid", Out_valid, 2'b01);
    chk("t3_dest", Out_dest, {6'd0, 6'd20});
    chk("t3_grabbed", Grabbed_regs, 1);
`else
    #1 chk("t3_pop", Pop_count, 0);
    @(posedge CLK); #1;
    chk("t3_valid", Out_valid, 2'b00);
    chk("t3_grabbed", Grabbed_regs, 0);
    chk("t3_frat_we", Frat_we, 2'b00);
`endif
    chk("t3_blocked", Blocked, 1);

    // ld + sw with one LSQ slot
    @(negedge CLK);
    clear_slots();
    slot(0, 5'd9, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
    slot(1, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    set_free(6'd30, 6'd31, 3'd2);
    Lsq_free_IN = 3'd1;
`ifdef RENAME_PARTIAL_DISPATCH_EN
    #1 chk("t4_pop", Pop_count, 1);
    @(posedge CLK); #1;
    chk("t4_valid", Out_valid, 2'b01);
`else
    #1 chk("t4_pop", Pop_count, 0);
    @(posedge CLK); #1;
    chk("t4_valid", Out_valid, 2'b00);
`endif
    chk("t4_blocked", Blocked, 1);

    // same pair with room
    @(negedge CLK); Lsq_free_IN = 3'd2; #1 chk("t4b_pop", Pop_count, 2);
    @(posedge CLK); #1;
    chk("t4b_valid", Out_valid, 2'b11);
    chk("t4b_lsq", Out_lsq, 2'b11);
    chk("t4b_has_dest", Out_has_dest, 2'b01);
    chk("t4b_dest", Out_dest, {6'd0, 6'd30});
    chk("t4b_src_a", Out_src_a, {6'd10, 6'd9});
    chk("t4b_src_b", Out_src_b, 0);
    chk("t4b_rdy_b", Out_rdy_b, 2'b11);
    chk("t4b_old", Out_old_dest, {6'd0, 6'd8});
    chk("t4b_arch", Frat_arch, {5'd0, 5'd8});
    chk("t4b_grabbed", Grabbed_regs, 1);
    chk("t4b_blocked", Blocked, 0);

    // empty group, then ROB budget boundary
    @(negedge CLK); clear_slots(); #1 chk("t5_pop_empty", Pop_count, 0);
    @(posedge CLK); #1 chk("t5_blocked_empty", Blocked, 1);
    @(negedge CLK);
    slot(0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    set_free(6'd50, 6'd51, 3'd2);
    Rob_free_IN = 3'd0;
    #1 chk("t5_pop_rob0", Pop_count, 0);
    @(posedge CLK); #1 chk("t5_blocked_rob0", Blocked, 1);
    @(negedge CLK); Rob_free_IN = 3'd1; #1 chk("t5_pop_rob1", Pop_count, 1);
    @(posedge CLK); #1;
    chk("t5_valid", Out_valid, 2'b01);
    chk("t5_dest", Out_dest, {6'd0, 6'd50});
    chk("t5_blocked", Blocked, 0);

    // flush window
    @(negedge CLK); Rob_free_IN = 3'd2; group1(); Flush_IN = 1'b1;
    #1 chk("f_pop_flush", Pop_count, 0);
    @(posedge CLK); #1;
    chk("f_valid0", Out_valid, 0);
    chk("f_blocked0", Blocked, 1);
    @(negedge CLK); Flush_IN = 1'b0; #1 chk("f_pop1", Pop_count, 0);
    @(posedge CLK); #1 chk("f_blocked1", Blocked, 1);
    @(negedge CLK); #1 chk("f_pop2", Pop_count, 0);
    @(posedge CLK); #1 chk("f_blocked2", Blocked, 1);
    @(negedge CLK); #1 chk("f_pop3", Pop_count, 2);
    @(posedge CLK); #1;
    chk("f_valid3", Out_valid, 2'b11);
    chk("f_blocked3", Blocked, 0);

    // second flush inside the window extends it
    @(negedge CLK); Flush_IN = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK); Flush_IN = 1'b1; #1 chk("ff_pop_a", Pop_count, 0);
    @(posedge CLK); #1;
    @(negedge CLK); Flush_IN = 1'b0; #1 chk("ff_pop_b", Pop_count, 0);
    @(posedge CLK); #1;
    @(negedge CLK); #1 chk("ff_pop_c", Pop_count, 0);
    @(posedge CLK); #1 chk("ff_blocked_c", Blocked, 1);
    @(negedge CLK); #1 chk("ff_pop_d", Pop_count, 2);
    @(posedge CLK); #1 chk("ff_valid_d", Out_valid, 2'b11);

    // reset pulse during traffic
    @(negedge CLK); RESET = 1'b0; #1 chk("r_pop", Pop_count, 0);
    @(posedge CLK); #1;
    chk("r_blocked", Blocked, 1);
    chk("r_valid", Out_valid, 0);
    chk("r_dest", Out_dest, 0);
    chk("r_grabbed", Grabbed_regs, 0);
    @(negedge CLK); RESET = 1'b1; #1 chk("r_pop_after", Pop_count, 2);
    @(posedge CLK); #1;
    chk("r_valid_after", Out_valid, 2'b11);
    chk("r_dest_after", Out_dest, {6'd41, 6'd40});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
